// File: rtl/dmem_bridge_pkg.sv
// Shared types for the MEM-stage data bus bridge: FSM states, access size codes
// and the latched bus request payload.
package dmem_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic              wr;
    mem_size_t         size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/dmem_bridge.sv
// Bridges the MEM-stage access onto an addr_ok/data_ok split-transaction data bus,
// stalling the pipeline until the access completes.
module dmem_bridge
  import dmem_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [STRB_W-1:0] mem_sel_i,
  input  logic [1:0]        mem_size_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_flush_i,
  input  logic              pipe_stall_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stallreq_o,
  output logic              req_o,
  output logic              wr_o,
  output logic [1:0]        size_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              addr_ok_i,
  input  logic              data_ok_i,
  input  logic [DATA_W-1:0] rdata_i
);

  state_t   state;
  logic     cancel;
  bus_req_t breq;
  logic     cancel_now;

  // A flush arriving in the same cycle as data_ok still discards the data.
  assign cancel_now = cancel | mem_flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cancel      <= 1'b0;
      req_o       <= 1'b0;
      breq        <= '0;
      mem_rdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cancel <= 1'b0;
          if (mem_en_i && !mem_flush_i) begin
            state      <= ST_ADDR;
            req_o      <= 1'b1;
            breq.wr    <= mem_we_i;
            breq.size  <= mem_size_t'(mem_size_i);
            breq.addr  <= mem_addr_i;
            breq.wstrb <= mem_we_i ? mem_sel_i : STRB_W'(0);
            breq.wdata <= mem_wdata_i;
          end
        end
        ST_ADDR: begin
          if (mem_flush_i) cancel <= 1'b1;
          if (addr_ok_i) begin
            req_o <= 1'b0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_flush_i) cancel <= 1'b1;
          if (data_ok_i) begin
            if (cancel_now) begin
              state  <= ST_IDLE;
              cancel <= 1'b0;
            end else begin
              state <= ST_DONE;
              if (!breq.wr) mem_rdata_o <= rdata_i;
            end
          end
        end
        ST_DONE: begin
          // Hold here until the pipeline advances so the same instruction is not reissued.
          if (!pipe_stall_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stallreq_o = ((state == ST_IDLE) && mem_en_i && !mem_flush_i)
                    || (state == ST_ADDR) || (state == ST_DATA);

  assign wr_o    = breq.wr;
  assign size_o  = breq.size;
  assign addr_o  = breq.addr;
  assign wstrb_o = breq.wstrb;
  assign wdata_o = breq.wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: directed accesses push expected bus requests and
// load results; a negedge monitor compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_i, mem_we_i, mem_flush_i, pipe_stall_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_rdata_o;
  logic        stallreq_o;
  logic        req_o, wr_o;
  logic [1:0]  size_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  wstrb_o;
  logic        addr_ok_i, data_ok_i;
  logic [31:0] rdata_i;

  dmem_bridge dut (
    .clk(clk), .rst(rst),
    .mem_en_i(mem_en_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_size_i(mem_size_i), .mem_wdata_i(mem_wdata_i),
    .mem_flush_i(mem_flush_i), .pipe_stall_i(pipe_stall_i),
    .mem_rdata_o(mem_rdata_o), .stallreq_o(stallreq_o),
    .req_o(req_o), .wr_o(wr_o), .size_o(size_o), .addr_o(addr_o),
    .wstrb_o(wstrb_o), .wdata_o(wdata_o),
    .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_count = 0;
  bus_req_t    exp_bus[$];
  logic [31:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_en_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    mem_size_i = '0; mem_wdata_i = '0; mem_flush_i = 1'b0; pipe_stall_i = 1'b0;
    addr_ok_i = 1'b0; data_ok_i = 1'b0; rdata_i = '0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [1:0] size, input logic [31:0] wdata);
    bus_req_t e;
    mem_en_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel;
    mem_size_i = size; mem_wdata_i = wdata;
    e.wr    = we;
    e.size  = mem_size_t'(size);
    e.addr  = addr;
    e.wstrb = we ? sel : 4'h0;
    e.wdata = wdata;
    exp_bus.push_back(e);
  endtask

  // Monitor: bus request fields while req_o is up, and load result after each data_ok.
  initial begin
    bus_req_t e;
    logic outstanding;
    logic pending;
    outstanding = 1'b0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 1'b0;
        pending = 1'b0;
      end else begin
        if (pending) begin
          pending = 1'b0;
          if (exp_rd.size() == 0) begin
            total++; bad++;
            $display("FAIL rdata_unexpected: got 0x%08h want no completion", mem_rdata_o);
          end else begin
            check("mem_rdata", mem_rdata_o, exp_rd.pop_front());
          end
        end
        if (outstanding && data_ok_i) begin
          outstanding = 1'b0;
          pending = 1'b1;
        end
        if (req_o) begin
          if (exp_bus.size() == 0) begin
            check("req_unexpected", 32'(req_o), 32'd0);
          end else begin
            e = exp_bus[0];
            check("wr_o", 32'(wr_o), 32'(e.wr));
            check("size_o", 32'(size_o), 32'(e.size));
            check("addr_o", addr_o, e.addr);
            check("wstrb_o", 32'(wstrb_o), 32'(e.wstrb));
            if (e.wr) check("wdata_o", wdata_o, e.wdata);
            if (addr_ok_i) begin
              void'(exp_bus.pop_front());
              outstanding = 1'b1;
              hs_count++;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int reqcnt;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    // Reset values; stallreq is live from IDLE even under reset
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    check("rst_wstrb", 32'(wstrb_o), 32'd0);
    mem_en_i = 1'b1; #1;
    check("rst_stallreq_en", 32'(stallreq_o), 32'd1);
    mem_flush_i = 1'b1; #1;
    check("rst_stallreq_flush", 32'(stallreq_o), 32'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();

    // Minimum-latency load
    issue(1'b0, 32'h0000_0010, 4'hF, 2'd2, 32'h0);
    exp_rd.push_back(32'hDEAD_BEEF);
    #1 check("a_stall_c0", 32'(stallreq_o), 32'd1);
    tick();
    addr_ok_i = 1'b1;
    #1 check("a_stall_c1", 32'(stallreq_o), 32'd1);
    check("a_req_c1", 32'(req_o), 32'd1);
    tick();
    addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    #1 check("a_stall_c2", 32'(stallreq_o), 32'd1);
    check("a_req_c2", 32'(req_o), 32'd0);
    tick();
    data_ok_i = 1'b0; rdata_i = '0;
    #1 check("a_rdata_c3", mem_rdata_o, 32'hDEAD_BEEF);
    check("a_stall_c3", 32'(stallreq_o), 32'd0);
    mem_en_i = 1'b0;
    tick();

    // Store with addr_ok held off 3 cycles; pipeline inputs scrambled to prove latching
    issue(1'b1, 32'h0000_0020, 4'b0011, 2'd1, 32'h1234_ABCD);
    exp_rd.push_back(32'hDEAD_BEEF);
    #1 check("b_stall_c0", 32'(stallreq_o), 32'd1);
    tick();
    mem_addr_i = 32'hFFFF_FFFC; mem_sel_i = 4'hF; mem_wdata_i = 32'h0; mem_size_i = 2'd0;
    reqcnt = 0;
    for (int i = 0; i < 4; i++) begin
      addr_ok_i = (i == 3);
      #1 if (req_o) reqcnt++;
      check("b_stall_addr", 32'(stallreq_o), 32'd1);
      tick();
    end
    addr_ok_i = 1'b0;
    check("b_req_cycles", 32'(reqcnt), 32'd4);
    data_ok_i = 1'b1; rdata_i = 32'hFFFF_0000;
    tick();
    data_ok_i = 1'b0;
    #1 check("b_stall_done", 32'(stallreq_o), 32'd0);
    check("b_rdata_kept", mem_rdata_o, 32'hDEAD_BEEF);
    mem_en_i = 1'b0;
    tick();

    // Load finishing under an external stall: sits in DONE, no reissue
    issue(1'b0, 32'h0000_0030, 4'h1, 2'd0, 32'h0);
    exp_rd.push_back(32'hCAFE_F00D);
    tick();
    addr_ok_i = 1'b1;
    tick();
    addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'hCAFE_F00D; pipe_stall_i = 1'b1;
    tick();
    data_ok_i = 1'b0; rdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      pipe_stall_i = (i < 2);
      if (i == 2) mem_en_i = 1'b0;
      #1 check("c_stall_done", 32'(stallreq_o), 32'd0);
      check("c_req_done", 32'(req_o), 32'd0);
      check("c_rdata_hold", mem_rdata_o, 32'hCAFE_F00D);
      tick();
    end

    // Flushed store in IDLE never reaches the bus
    mem_en_i = 1'b1; mem_we_i = 1'b1; mem_flush_i = 1'b1;
    mem_addr_i = 32'h0000_0080; mem_wdata_i = 32'h99; mem_sel_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 check("d_stall_flush", 32'(stallreq_o), 32'd0);
      check("d_req_flush", 32'(req_o), 32'd0);
      tick();
    end
    idle_inputs();
    tick();

    // Flush during DATA: old load discarded, new load issued after drain
    issue(1'b0, 32'h0000_0040, 4'hF, 2'd2, 32'h0);
    exp_rd.push_back(32'hCAFE_F00D);
    tick();
    addr_ok_i = 1'b1;
    tick();
    addr_ok_i = 1'b0; mem_flush_i = 1'b1;
    #1 check("e_stall_data", 32'(stallreq_o), 32'd1);
    tick();
    mem_flush_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h1111_2222;
    issue(1'b0, 32'h0000_0050, 4'hF, 2'd2, 32'h0);
    exp_rd.push_back(32'h55AA_55AA);
    #1 check("e_stall_drain", 32'(stallreq_o), 32'd1);
    tick();
    data_ok_i = 1'b0; rdata_i = '0;
    #1 check("e_stall_idle", 32'(stallreq_o), 32'd1);
    check("e_req_idle", 32'(req_o), 32'd0);
    check("e_rdata_kept", mem_rdata_o, 32'hCAFE_F00D);
    tick();
    addr_ok_i = 1'b1;
    #1 check("e_req_new", 32'(req_o), 32'd1);
    tick();
    addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h55AA_55AA;
    tick();
    data_ok_i = 1'b0;
    #1 check("e_rdata_new", mem_rdata_o, 32'h55AA_55AA);
    mem_en_i = 1'b0;
    tick();

    // Reset while in DATA abandons the access
    issue(1'b0, 32'h0000_0060, 4'hF, 2'd2, 32'h7777_7777);
    tick();
    addr_ok_i = 1'b1;
    tick();
    addr_ok_i = 1'b0; mem_en_i = 1'b0;
    rst = 1'b1;
    #1 check("g_req", 32'(req_o), 32'd0);
    check("g_wr", 32'(wr_o), 32'd0);
    check("g_size", 32'(size_o), 32'd0);
    check("g_addr", addr_o, 32'd0);
    check("g_wstrb", 32'(wstrb_o), 32'd0);
    check("g_wdata", wdata_o, 32'd0);
    check("g_rdata", mem_rdata_o, 32'd0);
    check("g_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("g_req_next", 32'(req_o), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back: load, then store accepted in the IDLE cycle right after DONE
    issue(1'b0, 32'h0000_0070, 4'hF, 2'd2, 32'h0);
    exp_rd.push_back(32'h0BAD_CAFE);
    tick();
    addr_ok_i = 1'b1;
    tick();
    addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h0BAD_CAFE;
    tick();
    data_ok_i = 1'b0;
    #1 check("f_stall_done", 32'(stallreq_o), 32'd0);
    tick();
    issue(1'b1, 32'h0000_0074, 4'hF, 2'd2, 32'hA5A5_A5A5);
    exp_rd.push_back(32'h0BAD_CAFE);
    #1 check("f_stall_idle", 32'(stallreq_o), 32'd1);
    tick();
    addr_ok_i = 1'b1;
    #1 check("f_req_store", 32'(req_o), 32'd1);
    tick();
    addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h1357_9BDF;
    tick();
    data_ok_i = 1'b0;
    #1 check("f_rdata_after_store", mem_rdata_o, 32'h0BAD_CAFE);
    mem_en_i = 1'b0;
    tick(); tick();

    check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("handshakes", 32'(hs_count), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
